mux2_stream_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 2:1 datapath mux. Two valid/ready requesters (x1, x2) contend for one output stream f.
- Drives the mux select s and the per-source ready signals. Enforces a bounded burst length so neither source can starve the other.
- Sits in front of the 2:1 mux datapath in the lab designs; the mux becomes a bus-wide instance controlled by this block.

---
 rtl/mux2_stream_arbiter_pkg.sv | 31 +++
 rtl/mux2_stream_arbiter_if.sv | 28 ++
 rtl/mux2_stream_arbiter_mux_2x1_bus.sv | 16 +
 rtl/mux2_stream_arbiter.sv | 127 ++++++++++++
 tb/tb_mux2_stream_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared encodings and helpers for the two-source stream arbiter.
package mux2_stream_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G1   = 2'd1,
      ST_G2   = 2'd2
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_X1   = 2'b01;
   localparam logic [1:0] GNT_X2   = 2'b10;

   // last_served encoding
   localparam logic SRC_X1 = 1'b0;
   localparam logic SRC_X2 = 1'b1;

   // Ceiling log2, used to size the burst counter
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux2_stream_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the output stream.
interface mux2_stream_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              x1_valid;
   logic [DATA_W-1:0] x1_data;
   logic              x1_ready;
   logic              x2_valid;
   logic [DATA_W-1:0] x2_data;
   logic              x2_ready;
   logic              f_valid;
   logic [DATA_W-1:0] f_data;
   logic              f_ready;
   logic              s;
   logic [1:0]        grant;

   // Arbiter side
   modport slave (
      input  x1_valid, x1_data, x2_valid, x2_data, f_ready,
      output x1_ready, x2_ready, f_valid, f_data, s, grant
   );

   // Environment side (sources and sink)
   modport master (
      output x1_valid, x1_data, x2_valid, x2_data, f_ready,
      input  x1_ready, x2_ready, f_valid, f_data, s, grant
   );
endinterface

// File: rtl/mux2_stream_arbiter_mux_2x1_bus.sv
// Bus-wide 2:1 mux: f follows x1 when s=0, x2 when s=1.
module mux_2x1_bus #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] x1,
   input  logic [DATA_W-1:0] x2,
   input  logic              s,
   output logic [DATA_W-1:0] f
);

   // Select the payload of the current owner
   always_comb begin
      f = s ? x2 : x1;
   end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter for a shared 2:1 stream mux with bounded bursts.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no owner; arbitrate on valids, s holds last value
// ST_G1   | x1 owns the output stream, counting its beats
// ST_G2   | x2 owns the output stream, counting its beats
module mux2_stream_arbiter
   import mux2_stream_arbiter_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mux2_stream_arbiter_if.slave bus
);

   localparam int              CNT_W    = clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             s_q, s_d;

   // State, burst counter, fairness pointer and select registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= SRC_X2;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         s_q     <= s_d;
      end
   end

   // Next-state: arbitration in idle, release and burst rotation while granted
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.x1_valid && bus.x2_valid) begin
               state_d = (last_q == SRC_X2) ? ST_G1 : ST_G2;
            end else if (bus.x1_valid) begin
               state_d = ST_G1;
            end else if (bus.x2_valid) begin
               state_d = ST_G2;
            end
         end
         ST_G1: begin
            if (!bus.x1_valid) begin
               state_d = bus.x2_valid ? ST_G2 : ST_IDLE;
               cnt_d   = '0;
               last_d  = SRC_X1;
            end else if (bus.f_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (bus.x2_valid) begin
                     state_d = ST_G2;
                     last_d  = SRC_X1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_G2: begin
            if (!bus.x2_valid) begin
               state_d = bus.x1_valid ? ST_G1 : ST_IDLE;
               cnt_d   = '0;
               last_d  = SRC_X2;
            end else if (bus.f_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (bus.x1_valid) begin
                     state_d = ST_G1;
                     last_d  = SRC_X2;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Select follows the upcoming owner and holds its value through idle
   always_comb begin
      s_d = s_q;
      if (state_d == ST_G1) begin
         s_d = 1'b0;
      end else if (state_d == ST_G2) begin
         s_d = 1'b1;
      end
   end

   // Handshake gating; reset kills every transfer in the same cycle
   assign bus.f_valid  = !reset && (((state_q == ST_G1) && bus.x1_valid) ||
                                    ((state_q == ST_G2) && bus.x2_valid));
   assign bus.x1_ready = !reset && (state_q == ST_G1) && bus.f_ready;
   assign bus.x2_ready = !reset && (state_q == ST_G2) && bus.f_ready;
   assign bus.s        = s_q;
   assign bus.grant    = (state_q == ST_G1) ? GNT_X1 :
                         (state_q == ST_G2) ? GNT_X2 : GNT_NONE;

   mux_2x1_bus #(
      .DATA_W (DATA_W)
   ) u_mux (
      .x1 (bus.x1_data),
      .x2 (bus.x2_data),
      .s  (s_q),
      .f  (bus.f_data)
   );

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench for mux2_stream_arbiter against a behavioural owner/burst model.
module tb_mux2_stream_arbiter;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   typedef logic [DATA_W+5:0] obs_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mux2_stream_arbiter_if #(.DATA_W(DATA_W)) bus ();

   mux2_stream_arbiter #(
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: owner 0=none, 1=x1, 2=x2; beats moved in the current burst
   int m_owner;
   int m_beats;
   int m_last;
   int m_sel;

   obs_t obs;
   assign obs = {bus.f_valid, bus.x1_ready, bus.x2_ready, bus.s, bus.grant, bus.f_data};

   function automatic obs_t model_out();
      logic              fv, r1, r2, sl;
      logic [1:0]        g;
      logic [DATA_W-1:0] d;
      g  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      fv = !reset && (((m_owner == 1) && bus.x1_valid) || ((m_owner == 2) && bus.x2_valid));
      r1 = !reset && (m_owner == 1) && bus.f_ready;
      r2 = !reset && (m_owner == 2) && bus.f_ready;
      sl = (m_sel == 1);
      d  = sl ? bus.x2_data : bus.x1_data;
      return {fv, r1, r2, sl, g, d};
   endfunction

   // Apply one clock edge worth of the arbitration rules to the model
   task automatic model_step();
      int own_v, oth_v, other;
      if (reset) begin
         m_owner = 0;
         m_beats = 0;
         m_last  = 2;
         m_sel   = 0;
         return;
      end
      if (m_owner == 0) begin
         if (bus.x1_valid && bus.x2_valid) m_owner = 3 - m_last;
         else if (bus.x1_valid)            m_owner = 1;
         else if (bus.x2_valid)            m_owner = 2;
      end else begin
         other = 3 - m_owner;
         own_v = (m_owner == 1) ? int'(bus.x1_valid) : int'(bus.x2_valid);
         oth_v = (other == 1)   ? int'(bus.x1_valid) : int'(bus.x2_valid);
         if (own_v == 0) begin
            m_last  = m_owner;
            m_owner = (oth_v != 0) ? other : 0;
            m_beats = 0;
         end else if (bus.f_ready) begin
            m_beats = m_beats + 1;
            if (m_beats == MAX_BURST) begin
               m_beats = 0;
               if (oth_v != 0) begin
                  m_last  = m_owner;
                  m_owner = other;
               end
            end
         end
      end
      if (m_owner == 1) m_sel = 0;
      else if (m_owner == 2) m_sel = 1;
   endtask

   task automatic drive(input logic v1, input logic v2, input logic fr);
      bus.x1_valid = v1;
      bus.x2_valid = v2;
      bus.f_ready  = fr;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.x1_data = 8'h11;
      bus.x2_data = 8'h22;
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs[DATA_W+5:DATA_W] !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset cyc %0d: got fv/r1/r2/s/grant=%b, want 000000", i, obs[DATA_W+5:DATA_W]);
         end
         model_step();
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bus.x1_data = 8'hA5;
      bus.x2_data = 8'h5A;
      drive(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL single cyc %0d: got %h, want %h", i, obs, model_out());
         end
         if (i == 1) begin
            n_checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'hA5}) begin
               n_fail++;
               $display("FAIL single_grant: got %h, want %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'hA5});
            end
         end
         model_step();
         @(posedge clk);
         #1;
      end
      drive(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_contention();
      logic [1:0] want_g;
      apply_reset();
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         bus.x1_data = 8'($urandom);
         bus.x2_data = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL contention cyc %0d: got %h, want %h", i, obs, model_out());
         end
         if (i >= 1) begin
            want_g = ((((i - 1) / MAX_BURST) % 2) == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if ({bus.f_valid, bus.grant} !== {1'b1, want_g}) begin
               n_fail++;
               $display("FAIL contention_pattern cyc %0d: got fv,grant=%b, want %b", i, {bus.f_valid, bus.grant}, {1'b1, want_g});
            end
         end
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      // cycle 0 idle, 1-2 beats, 3-5 stalled, 6-7 beats 3/4, then x2 owns
      logic fr_seq [0:9];
      fr_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      apply_reset();
      bus.x1_data = 8'h3C;
      bus.x2_data = 8'hC3;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, fr_seq[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL backpressure cyc %0d: got %h, want %h", i, obs, model_out());
         end
         if (i >= 3 && i <= 7) begin
            n_checks++;
            if ({bus.grant, bus.f_data} !== {2'b01, 8'h3C}) begin
               n_fail++;
               $display("FAIL backpressure_hold cyc %0d: got %h, want %h", i, {bus.grant, bus.f_data}, {2'b01, 8'h3C});
            end
         end
         if (i == 8) begin
            n_checks++;
            if (bus.grant !== 2'b10) begin
               n_fail++;
               $display("FAIL backpressure_handover: got grant %b, want 10", bus.grant);
            end
         end
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_early_release();
      apply_reset();
      bus.x1_data = 8'h01;
      bus.x2_data = 8'h02;
      for (int i = 0; i < 12; i++) begin
         // x1 moves two beats, drops at cycle 3; x2 alone until x1 returns at cycle 7
         drive((i < 3) || (i >= 7), 1'b1, 1'b1);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL early_release cyc %0d: got %h, want %h", i, obs, model_out());
         end
         if (i == 4 || i == 7) begin
            n_checks++;
            if ({bus.grant, bus.s} !== 3'b101) begin
               n_fail++;
               $display("FAIL early_release_grant cyc %0d: got grant,s=%b, want 101", i, {bus.grant, bus.s});
            end
         end
         if (i == 8) begin
            n_checks++;
            if (bus.grant !== 2'b01) begin
               n_fail++;
               $display("FAIL early_release_count: got grant %b, want 01", bus.grant);
            end
         end
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      bus.x1_data = 8'h77;
      bus.x2_data = 8'h88;
      for (int i = 0; i < 7; i++) begin
         reset = (i == 3);
         drive(i >= 4, 1'b1, 1'b1);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL mid_reset cyc %0d: got %h, want %h", i, obs, model_out());
         end
         if (i == 3) begin
            n_checks++;
            if ({bus.f_valid, bus.x1_ready, bus.x2_ready, bus.grant} !== 5'b00010) begin
               n_fail++;
               $display("FAIL mid_reset_kill: got %b, want 00010", {bus.f_valid, bus.x1_ready, bus.x2_ready, bus.grant});
            end
         end
         if (i == 4 || i == 5) begin
            n_checks++;
            if (bus.grant !== ((i == 4) ? 2'b00 : 2'b01)) begin
               n_fail++;
               $display("FAIL mid_reset_rearb cyc %0d: got grant %b, want %b", i, bus.grant, (i == 4) ? 2'b00 : 2'b01);
            end
         end
         model_step();
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 500; i++) begin
         reset = ($urandom_range(0, 79) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         bus.x1_data = 8'($urandom);
         bus.x2_data = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %h, want %h", i, obs, model_out());
         end
         model_step();
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      bus.x1_valid = 1'b0;
      bus.x2_valid = 1'b0;
      bus.f_ready  = 1'b0;
      bus.x1_data  = '0;
      bus.x2_data  = '0;
      m_owner      = 0;
      m_beats      = 0;
      m_last       = 2;
      m_sel        = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_early_release();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
